// File: rtl/uart_port_bridge_pkg.sv
// Shared types and constants for the UART-to-port-bus command bridge.
// Holds the FSM state encoding, command opcodes and default response bytes.
package uart_port_bridge_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned LAT_W  = 2;
  localparam int unsigned TO_W   = 20;

  localparam logic [BYTE_W-1:0] OP_WR   = 8'h57;  // 'W'
  localparam logic [BYTE_W-1:0] OP_RD   = 8'h52;  // 'R'
  localparam logic [BYTE_W-1:0] ACK_DEF = 8'h06;
  localparam logic [BYTE_W-1:0] NAK_DEF = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_AH,
    ST_GET_AL,
    ST_GET_DH,
    ST_GET_DL,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RD_WAIT,
    ST_TX,
    ST_TX_WAIT
  } state_e;

endpackage

// File: rtl/uart_port_bridge_tx_queue.sv
// Two-entry response byte queue feeding the bridge transmit handshake.
// Ports: clk/rst_n; push1_i loads din_i[7:0] as a single byte; push2_i loads
// din_i[15:8] then din_i[7:0]; pop_i drops the head; head_o/count_o show
// the oldest byte and the number of queued bytes.
module bridge_tx_queue
  import uart_port_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push1_i,
  input  logic              push2_i,
  input  logic [WORD_W-1:0] din_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [BYTE_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;

  // Pushes only occur while the queue is empty, so they overwrite outright.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (push2_i) begin
      ent0_d = din_i[15:8];
      ent1_d = din_i[7:0];
      cnt_d  = 2'd2;
    end else if (push1_i) begin
      ent0_d = din_i[7:0];
      cnt_d  = 2'd1;
    end else if (pop_i && (cnt_q != 2'd0)) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = ent0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/uart_port_bridge.sv
// Serial-command initiator for the 16-bit port bus. Decodes 'W' AH AL DH DL
// and 'R' AH AL commands from the UART rx engine, issues single-cycle
// write/read strobes and answers with ACK, NAK or two read-data bytes.
// Ports: rx_data_i/rx_rdy_i/rx_err_i/rx_read_o (rx engine), tx_rdy_i/tx_ld_o/
// tx_data_o (tx engine), port_id_o/out_port_o/in_port_i/write_strobe_o/
// read_strobe_o (port bus), busy_o (FSM not idle).
// Optional: define UART_PORT_BRIDGE_TIMEOUT_EN to abort partial commands
// after TO_CYCLES idle cycles with a NAK.
module uart_port_bridge
  import uart_port_bridge_pkg::*;
#(
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [BYTE_W-1:0] ACK_BYTE = ACK_DEF,
  parameter logic [BYTE_W-1:0] NAK_BYTE = NAK_DEF
`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
  ,
  parameter logic [TO_W-1:0]   TO_CYCLES = 20'd1_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_rdy_i,
  input  logic              rx_err_i,
  output logic              rx_read_o,
  input  logic              tx_rdy_i,
  output logic              tx_ld_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic [WORD_W-1:0] port_id_o,
  output logic [WORD_W-1:0] out_port_o,
  input  logic [WORD_W-1:0] in_port_i,
  output logic              write_strobe_o,
  output logic              read_strobe_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] data_hi_q, data_hi_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              rx_read_q, rx_read_d;
  logic              tx_ld_q, tx_ld_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [WORD_W-1:0] port_id_q, port_id_d;
  logic [WORD_W-1:0] out_port_q, out_port_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`endif

  logic              take_c;
  logic              q_push1_c, q_push2_c, q_pop_c;
  logic [WORD_W-1:0] q_din_c;
  logic [BYTE_W-1:0] q_head;
  logic [1:0]        q_count;

  // A byte is accepted only outside the guard cycle that follows rx_read.
  assign take_c = rx_rdy_i && !rx_read_q;

  bridge_tx_queue u_txq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push1_i (q_push1_c),
    .push2_i (q_push2_c),
    .din_i   (q_din_c),
    .pop_i   (q_pop_c),
    .head_o  (q_head),
    .count_o (q_count)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    data_hi_d  = data_hi_q;
    lat_d      = lat_q;
    tx_data_d  = tx_data_q;
    port_id_d  = port_id_q;
    out_port_d = out_port_q;
    rx_read_d  = 1'b0;
    tx_ld_d    = 1'b0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    q_push1_c  = 1'b0;
    q_push2_c  = 1'b0;
    q_pop_c    = 1'b0;
    q_din_c    = '0;
`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    unique case (state_q)
      ST_IDLE, ST_GET_AH, ST_GET_AL, ST_GET_DH, ST_GET_DL: begin
        if (take_c) begin
          rx_read_d = 1'b1;
          if (rx_err_i) begin
            q_push1_c = 1'b1;
            q_din_c   = {8'h00, NAK_BYTE};
            state_d   = ST_TX;
          end else begin
            unique case (state_q)
              ST_IDLE: begin
                if (rx_data_i == OP_WR) begin
                  op_wr_d = 1'b1;
                  state_d = ST_GET_AH;
                end else if (rx_data_i == OP_RD) begin
                  op_wr_d = 1'b0;
                  state_d = ST_GET_AH;
                end else begin
                  q_push1_c = 1'b1;
                  q_din_c   = {8'h00, NAK_BYTE};
                  state_d   = ST_TX;
                end
              end
              ST_GET_AH: begin
                addr_d[15:8] = rx_data_i;
                state_d      = ST_GET_AL;
              end
              ST_GET_AL: begin
                addr_d[7:0] = rx_data_i;
                if (op_wr_q) begin
                  state_d = ST_GET_DH;
                end else begin
                  // Read strobes together with the address it targets.
                  port_id_d = {addr_q[15:8], rx_data_i};
                  rd_d      = 1'b1;
                  state_d   = ST_BUS_RD;
                end
              end
              ST_GET_DH: begin
                data_hi_d = rx_data_i;
                state_d   = ST_GET_DL;
              end
              default: begin
                // Bus lines settle one cycle ahead of the write strobe.
                port_id_d  = addr_q;
                out_port_d = {data_hi_q, rx_data_i};
                state_d    = ST_BUS_WR;
              end
            endcase
          end
        end
      end
      ST_BUS_WR: begin
        wr_d      = 1'b1;
        q_push1_c = 1'b1;
        q_din_c   = {8'h00, ACK_BYTE};
        state_d   = ST_TX;
      end
      ST_BUS_RD: begin
        lat_d   = LAT_W'(RD_LAT);
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == '0) begin
          q_push2_c = 1'b1;
          q_din_c   = in_port_i;
          state_d   = ST_TX;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_TX: begin
        if (tx_rdy_i) begin
          tx_data_d = q_head;
          tx_ld_d   = 1'b1;
          q_pop_c   = 1'b1;
          state_d   = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        // tx_rdy is stale in the cycle tx_ld is visible to the tx engine.
        if (tx_rdy_i && !tx_ld_q) begin
          state_d = (q_count != 2'd0) ? ST_TX : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
    // Inter-byte timeout while a command is partially received.
    if ((state_q inside {ST_GET_AH, ST_GET_AL, ST_GET_DH, ST_GET_DL}) && !take_c) begin
      if (to_cnt_q == TO_CYCLES) begin
        q_push1_c = 1'b1;
        q_din_c   = {8'h00, NAK_BYTE};
        state_d   = ST_TX;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_hi_q  <= '0;
      lat_q      <= '0;
      rx_read_q  <= 1'b0;
      tx_ld_q    <= 1'b0;
      tx_data_q  <= '0;
      port_id_q  <= '0;
      out_port_q <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      data_hi_q  <= data_hi_d;
      lat_q      <= lat_d;
      rx_read_q  <= rx_read_d;
      tx_ld_q    <= tx_ld_d;
      tx_data_q  <= tx_data_d;
      port_id_q  <= port_id_d;
      out_port_q <= out_port_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign rx_read_o      = rx_read_q;
  assign tx_ld_o        = tx_ld_q;
  assign tx_data_o      = tx_data_q;
  assign port_id_o      = port_id_q;
  assign out_port_o     = out_port_q;
  assign write_strobe_o = wr_q;
  assign read_strobe_o  = rd_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_port_bridge.sv
// Directed bench for uart_port_bridge: models the rx/tx engines and a
// registered-output bus slave, and checks strobes, bus values and responses.
module tb_uart_port_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_err;
  logic        rx_read;
  logic        tx_rdy = 1'b1;
  logic        tx_ld;
  logic [7:0]  tx_data;
  logic [15:0] port_id;
  logic [15:0] out_port;
  logic [15:0] in_port = 16'h0000;
  logic        write_strobe;
  logic        read_strobe;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state
  int          cyc = 0;
  int          last_rx_cyc = 0;
  int          wr_n = 0, rd_n = 0, both_n = 0, wr_unstable = 0;
  int          wr_cyc = 0, rd_cyc = 0;
  logic [15:0] wr_pid = '0, wr_dat = '0, rd_pid = '0;
  logic [15:0] prev_pid = '0, prev_dat = '0;
  logic [15:0] rd_value = 16'h0000;
  logic        rd_pend = 1'b0;
  logic [7:0]  tx_log [0:63];
  int          tx_n = 0, tx_bad = 0, tx_bsy = 0;

  always #5 clk = ~clk;

  uart_port_bridge #(
    .RD_LAT(1)
`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
    , .TO_CYCLES(20'd100)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data_i      (rx_data),
    .rx_rdy_i       (rx_rdy),
    .rx_err_i       (rx_err),
    .rx_read_o      (rx_read),
    .tx_rdy_i       (tx_rdy),
    .tx_ld_o        (tx_ld),
    .tx_data_o      (tx_data),
    .port_id_o      (port_id),
    .out_port_o     (out_port),
    .in_port_i      (in_port),
    .write_strobe_o (write_strobe),
    .read_strobe_o  (read_strobe),
    .busy_o         (busy)
  );

  // Bus slave, tx engine and strobe monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_read === 1'b1) last_rx_cyc = cyc;
    if (write_strobe === 1'b1) begin
      wr_n = wr_n + 1;
      wr_pid = port_id;
      wr_dat = out_port;
      wr_cyc = cyc;
      if (port_id !== prev_pid || out_port !== prev_dat) wr_unstable = wr_unstable + 1;
    end
    if (write_strobe === 1'b1 && read_strobe === 1'b1) both_n = both_n + 1;
    if (rd_pend) begin
      in_port = rd_value;
      rd_pend = 1'b0;
    end
    if (read_strobe === 1'b1) begin
      rd_n = rd_n + 1;
      rd_pid = port_id;
      rd_cyc = cyc;
      rd_pend = 1'b1;
      in_port = 16'hDEAD;
    end
    if (rst_n !== 1'b1) begin
      tx_rdy = 1'b1;
      tx_bsy = 0;
    end else if (tx_ld === 1'b1) begin
      if (tx_rdy !== 1'b1) tx_bad = tx_bad + 1;
      if (tx_n < 64) tx_log[tx_n] = tx_data;
      tx_n = tx_n + 1;
      tx_rdy = 1'b0;
      tx_bsy = 4;
    end else if (tx_bsy > 0) begin
      tx_bsy = tx_bsy - 1;
      if (tx_bsy == 0) tx_rdy = 1'b1;
    end
    prev_pid = port_id;
    prev_dat = out_port;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    rx_data = b;
    rx_err = e;
    rx_rdy = 1'b1;
    while (!seen && n < 100) begin
      @(negedge clk);
      n = n + 1;
      if (rx_read === 1'b1) seen = 1'b1;
    end
    rx_rdy = 1'b0;
    rx_err = 1'b0;
    chk("rx_consume", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n = n + 1;
    end
    chk(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({rx_read, tx_ld, write_strobe, read_strobe, busy}), 32'd0);
    chk({tag, "_txd"}, 32'(tx_data), 32'd0);
    chk({tag, "_pid"}, 32'(port_id), 32'd0);
    chk({tag, "_out"}, 32'(out_port), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rd0, tx0;
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_rdy = 1'b0;
    rx_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 8010 <= BEEF, expect ACK
    wr0 = wr_n; rd0 = rd_n; tx0 = tx_n;
    send_byte(8'h57, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    wait_idle("wr_idle");
    chk("wr_count", 32'(wr_n - wr0), 32'd1);
    chk("wr_pid", 32'(wr_pid), 32'h8010);
    chk("wr_data", 32'(wr_dat), 32'hBEEF);
    chk("wr_stable", 32'(wr_unstable), 32'd0);
    chk("wr_latency", 32'(wr_cyc - (last_rx_cyc - 1)), 32'd2);
    chk("wr_no_read", 32'(rd_n - rd0), 32'd0);
    chk("wr_tx_n", 32'(tx_n - tx0), 32'd1);
    chk("wr_ack", 32'(tx_log[tx0]), 32'h06);

    // Read 8010 -> 1234, expect 12 then 34
    rd_value = 16'h1234;
    wr0 = wr_n; rd0 = rd_n; tx0 = tx_n;
    send_byte(8'h52, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'h10, 1'b0);
    wait_idle("rd_idle");
    chk("rd_count", 32'(rd_n - rd0), 32'd1);
    chk("rd_pid", 32'(rd_pid), 32'h8010);
    chk("rd_latency", 32'(rd_cyc - (last_rx_cyc - 1)), 32'd1);
    chk("rd_no_write", 32'(wr_n - wr0), 32'd0);
    chk("rd_tx_n", 32'(tx_n - tx0), 32'd2);
    chk("rd_tx_hi", 32'(tx_log[tx0]), 32'h12);
    chk("rd_tx_lo", 32'(tx_log[tx0 + 1]), 32'h34);
    chk("tx_handshake", 32'(tx_bad), 32'd0);

    // Bad opcode -> NAK, then a normal read of 0002
    wr0 = wr_n; rd0 = rd_n; tx0 = tx_n;
    send_byte(8'h41, 1'b0);
    wait_idle("bad_idle");
    chk("bad_tx_n", 32'(tx_n - tx0), 32'd1);
    chk("bad_nak", 32'(tx_log[tx0]), 32'h15);
    chk("bad_no_bus", 32'((wr_n - wr0) + (rd_n - rd0)), 32'd0);
    rd_value = 16'hA55A;
    tx0 = tx_n;
    send_byte(8'h52, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    wait_idle("rd2_idle");
    chk("rd2_count", 32'(rd_n - rd0), 32'd1);
    chk("rd2_pid", 32'(rd_pid), 32'h0002);
    chk("rd2_tx_hi", 32'(tx_log[tx0]), 32'hA5);
    chk("rd2_tx_lo", 32'(tx_log[tx0 + 1]), 32'h5A);

    // rx_err on the AL byte of a write -> NAK, no strobe
    wr0 = wr_n; tx0 = tx_n;
    send_byte(8'h57, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    wait_idle("err_idle");
    chk("err_tx_n", 32'(tx_n - tx0), 32'd1);
    chk("err_nak", 32'(tx_log[tx0]), 32'h15);
    chk("err_no_write", 32'(wr_n - wr0), 32'd0);

    // Reset while waiting for DH aborts everything immediately
    tx0 = tx_n;
    send_byte(8'h57, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'h10, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_tx", 32'(tx_n - tx0), 32'd0);
    wr0 = wr_n; tx0 = tx_n;
    send_byte(8'h57, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    wait_idle("post_idle");
    chk("post_count", 32'(wr_n - wr0), 32'd1);
    chk("post_pid", 32'(wr_pid), 32'h0005);
    chk("post_data", 32'(wr_dat), 32'h1234);
    chk("post_ack", 32'(tx_log[tx0]), 32'h06);

    // Stalled partial command
    tx0 = tx_n;
    send_byte(8'h57, 1'b0);
    send_byte(8'h80, 1'b0);
    repeat (150) @(negedge clk);
`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_tx_n", 32'(tx_n - tx0), 32'd1);
    chk("to_nak", 32'(tx_log[tx0]), 32'h15);
`else
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_tx_n", 32'(tx_n - tx0), 32'd0);
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("strobes_exclusive", 32'(both_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
